// File: rtl/demux1x4_unstripe_if.sv
// Byte-stream input and framed four-lane output bundle of the receive un-striper.
interface demux1x4_unstripe_if #(
    parameter int BW = 8
);
    logic [BW-1:0] in;
    logic          validin;
    logic [BW-1:0] out0;
    logic [BW-1:0] out1;
    logic [BW-1:0] out2;
    logic [BW-1:0] out3;
    logic [3:0]    validout;
    logic          frame_done;

    modport master (
        output in,
        output validin,
        input  out0,
        input  out1,
        input  out2,
        input  out3,
        input  validout,
        input  frame_done
    );

    modport slave (
        input  in,
        input  validin,
        output out0,
        output out1,
        output out2,
        output out3,
        output validout,
        output frame_done
    );
endinterface

// File: rtl/demux1x4_unstripe.sv
// Receive-side byte un-striper: spreads one byte slot per clk4f edge across four lanes
// and presents the lanes together once per four-slot frame.
module demux1x4_unstripe #(
    parameter int BW          = 8,
    parameter int IDLE_FRAMES = 1
) (
    input  logic                clk4f,
    input  logic                reset,
    demux1x4_unstripe_if.slave  bus
);

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_ACTIVE = 1'b1;
    localparam logic [3:0] IDLE_LIMIT = 4'(IDLE_FRAMES);

    logic [0:0]    state;
    logic [1:0]    ptr;
    logic [BW-1:0] hold0;
    logic [BW-1:0] hold1;
    logic [BW-1:0] hold2;
    logic [2:0]    hold_valid;
    logic [3:0]    idle_cnt;
    logic [3:0]    frame_valid;
    logic [3:0]    idle_next;

    assign frame_valid = {bus.validin, hold_valid};
    assign idle_next   = idle_cnt + 4'd1;

    // Lane position is purely positional: ptr advances every ACTIVE edge, valid or not,
    // and invalid lanes are zeroed on the way out so no stale byte is ever presented.
    always_ff @(posedge clk4f or negedge reset) begin
        if (!reset) begin
            state          <= ST_IDLE;
            ptr            <= 2'd0;
            hold0          <= '0;
            hold1          <= '0;
            hold2          <= '0;
            hold_valid     <= 3'b000;
            idle_cnt       <= 4'd0;
            bus.out0       <= '0;
            bus.out1       <= '0;
            bus.out2       <= '0;
            bus.out3       <= '0;
            bus.validout   <= 4'b0000;
            bus.frame_done <= 1'b0;
        end else begin
            bus.frame_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.validin) begin
                        hold0      <= bus.in;
                        hold_valid <= 3'b001;
                        ptr        <= 2'd1;
                        state      <= ST_ACTIVE;
                    end
                end
                ST_ACTIVE: begin
                    ptr <= ptr + 2'd1;
                    case (ptr)
                        2'd0: begin
                            hold0         <= bus.in;
                            hold_valid[0] <= bus.validin;
                        end
                        2'd1: begin
                            hold1         <= bus.in;
                            hold_valid[1] <= bus.validin;
                        end
                        2'd2: begin
                            hold2         <= bus.in;
                            hold_valid[2] <= bus.validin;
                        end
                        default: begin
                            bus.out0       <= hold_valid[0] ? hold0 : '0;
                            bus.out1       <= hold_valid[1] ? hold1 : '0;
                            bus.out2       <= hold_valid[2] ? hold2 : '0;
                            bus.out3       <= bus.validin ? bus.in : '0;
                            bus.validout   <= frame_valid;
                            bus.frame_done <= 1'b1;
                            // Enough consecutive empty frames drop alignment; the next valid byte re-anchors lane 0.
                            if (frame_valid == 4'b0000) begin
                                if (idle_next == IDLE_LIMIT) begin
                                    state    <= ST_IDLE;
                                    idle_cnt <= 4'd0;
                                end else begin
                                    idle_cnt <= idle_next;
                                end
                            end else begin
                                idle_cnt <= 4'd0;
                            end
                        end
                    endcase
                end
                default: begin
                    state <= ST_IDLE;
                    ptr   <= 2'd0;
                end
            endcase
        end
    end

endmodule

// File: doc/demux1x4_unstripe.md
Name: demux1x4_unstripe

Overview:
- Receive-side byte un-striper for the PHY Layer PCIe datapath; inverse of the transmit 4-lane-to-1 byte gather.
- Takes one byte stream plus a valid bit at the 4f rate and distributes consecutive byte slots round-robin into four lanes.
- Presents all four lanes and their per-lane valids together, once per 4-slot frame.
- Single clock domain; frame alignment is set by the first valid byte after idle.

Parameters:
- BW, 8, data width per lane and of the input stream.
- IDLE_FRAMES, 1, number of consecutive all-invalid frames that return the block to IDLE (legal range 1..15).

Ports:
- clk4f  input  1  single clock; the stream rate, one byte slot per rising edge.
- reset  input  1  asynchronous, active-low; 0 clears all state immediately.
- in  input  BW  input data byte.
- validin  input  1  1 = `in` carries a valid byte this cycle.
- out0  output  BW  lane 0 byte of the last completed frame.
- out1  output  BW  lane 1 byte of the last completed frame.
- out2  output  BW  lane 2 byte of the last completed frame.
- out3  output  BW  lane 3 byte of the last completed frame.
- validout  output  4  per-lane valid of the last completed frame; bit i belongs to out_i.
- frame_done  output  1  one-cycle pulse when out0..out3 and validout update.

Behaviour:
- Reset (reset=0, asynchronous):
  - out0..out3 = 0, validout = 4'b0000, frame_done = 0.
  - ptr = 0, all holding registers and holding valids = 0, idle_cnt = 0, state = IDLE.
  - Any partial frame is discarded. The first edge after release behaves as IDLE.
- State IDLE:
  - ptr is held at 0.
  - validin=0: nothing is stored and outputs hold.
  - validin=1: store `in` into hold0, set hold-valid0 = 1, ptr -> 1, go to ACTIVE. This byte is lane 0 of the first frame.
- State ACTIVE, every edge:
  - Store `in` into hold[ptr] and validin into hold-valid[ptr].
  - ptr increments modulo 4 on every edge, whether or not validin is set. Lane position is positional, not packed.
- Frame completion (edge where ptr==3 in ACTIVE):
  - out_i <= hold_i for lanes 0..2, and out3 <= `in` of the current cycle.
  - validout <= {validin, hold-valid2, hold-valid1, hold-valid0}.
  - frame_done <= 1 for exactly one cycle; ptr -> 0.
  - Any lane whose valid is 0 drives out_i = 0, never stale data.
- Latency: the lane 3 byte appears on out3 after the same edge that samples it. The lane 0 byte appears 3 edges after it is sampled.
- Between completions, out0..out3 and validout hold their values and frame_done = 0.
- Idle detection:
  - At each frame completion, an all-invalid frame (4'b0000) increments idle_cnt; any other frame clears it.
  - If the increment brings idle_cnt to IDLE_FRAMES, the state goes to IDLE at that same edge.
  - That all-invalid frame is still presented: validout=0, data=0, frame_done=1.
- Simultaneous events: asynchronous reset overrides every edge event. A frame completion and the IDLE transition on the same edge are both performed as above.
- A valid byte arriving on the edge that enters IDLE is part of the completed frame (lane 3). It does not start a new frame.
- No backpressure: the block always accepts `in`.

Test Plan:
- Reset: hold reset=0 with in=8'hFF and validin=1 -> out0..3=0, validout=0, frame_done=0. Assert reset mid-frame after 2 valid bytes -> outputs clear immediately, and the next valid byte after release lands in lane 0.
- Full frame: after reset release, send AA,BB,CC,DD with validin=1 on 4 consecutive edges -> after the 4th edge out0=AA, out1=BB, out2=CC, out3=DD, validout=4'b1111, frame_done high for exactly 1 cycle.
- Alignment: send 2 idle cycles (validin=0), then 11,22,33,44 valid -> frame_done only after 44, out0=11, validout=4'b1111.
- Partial frame: in ACTIVE send 55(v=1), 66(v=0), 77(v=1), 88(v=0) -> out0=55, out1=00, out2=77, out3=00, validout=4'b0101.
- Back-to-back: 8 consecutive valid bytes 01..08 -> two frame_done pulses 4 cycles apart; the second frame gives out0..3 = 05,06,07,08. Outputs hold between pulses.
- Idle return (IDLE_FRAMES=1): after a valid frame, send 4 invalid slots -> validout=0, frame_done pulses, state=IDLE. Then 2 idle cycles and valid 9A -> 9A lands in out0 of the next frame, with realignment independent of the prior ptr phase.
